uart_rx: RTL and testbench

Asynchronous serial receiver for 8N1 frames, LSB first, idle-high line. It pairs with the design's UART transmitter and decodes one byte per frame, flagging framing errors. A build-time option adds a checker that recognises the 13-byte "Tiny Tapeout " banner in the received stream, so the transmitter can be looped back and self-tested on silicon.

---
 rtl/uart_rx.sv | 170 +++++++++++++++++
 tb/tb_uart_rx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, idle-high line, with framing-error detect.
// Build option UART_RX_MATCH_EN adds a checker that pulses `match` on each complete
// "Tiny Tapeout " banner in the received byte stream; otherwise `match` is tied low.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  output logic       match
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } state_t;

  state_t           state_q, state_d;
  logic             rx_meta, rxs;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       rx_data_d;
  logic             rx_valid_d, frame_err_d, busy_d;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_pin;
      rxs     <= rx_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: start detect, mid-bit sampling, break hold-off.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (!rxs) state_d = S_START;
      S_START:     if (cnt_q == HALF_LAST) state_d = rxs ? S_IDLE : S_DATA;
      S_DATA:      if (cnt_q == BIT_LAST && bit_idx_q == 3'd7) state_d = S_STOP;
      S_STOP:      if (cnt_q == BIT_LAST) state_d = rxs ? S_IDLE : S_WAIT_HIGH;
      S_WAIT_HIGH: if (rxs) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values: counters, shifter, result pulses.
  always_comb begin
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    busy_d      = (state_d != S_IDLE);
    case (state_q)
      S_IDLE: cnt_d = '0;
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          shift_d = {rxs, shift_q[7:1]};
          if (bit_idx_q != 3'd7) bit_idx_d = bit_idx_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxs) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
          end else begin
            frame_err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WAIT_HIGH: cnt_d = '0;
      default: cnt_d = '0;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      rx_data   <= rx_data_d;
      rx_valid  <= rx_valid_d;
      frame_err <= frame_err_d;
      busy      <= busy_d;
    end
  end

`ifdef UART_RX_MATCH_EN
  localparam int unsigned BANNER_LEN = 13;
  localparam logic [7:0] BANNER [BANNER_LEN] = '{
    8'h54, 8'h69, 8'h6E, 8'h79, 8'h20, 8'h54, 8'h61,
    8'h70, 8'h65, 8'h6F, 8'h75, 8'h74, 8'h20
  };

  logic [3:0] idx_q;

  // Banner tracker; a stray 'T' restarts the match at position 1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx_q <= 4'd0;
      match <= 1'b0;
    end else begin
      match <= 1'b0;
      if (frame_err) begin
        idx_q <= 4'd0;
      end else if (rx_valid) begin
        if (rx_data == BANNER[idx_q]) begin
          if (idx_q == 4'(BANNER_LEN - 1)) begin
            match <= 1'b1;
            idx_q <= 4'd0;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end else begin
          idx_q <= (rx_data == 8'h54) ? 4'd1 : 4'd0;
        end
      end
    end
  end
`else
  assign match = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame table, scoreboard queue, hand-written corner cases.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int unsigned CPB = 4;
`ifdef UART_RX_MATCH_EN
  localparam int unsigned MATCH_ON = 1;
`else
  localparam int unsigned MATCH_ON = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_pin = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, busy, match;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_pin    (rx_pin),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy),
    .match     (match)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       err;
  } exp_t;

  typedef struct {
    logic [7:0] din;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_err;
  } vec_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  vec_t       vt[7];
  logic [7:0] banner[13];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0, err_cnt = 0, match_cnt = 0;
  int last_valid_cyc = 0, prev_valid_cyc = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      if (rx_valid || frame_err) begin
        check("valid_err_exclusive", 32'(rx_valid & frame_err), 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output valid=%0b err=%0b data=%02h required=none",
                   rx_valid, frame_err, rx_data);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_kind_err", 32'(frame_err), 32'(mon_e.err));
          if (!mon_e.err) check("rx_data", 32'(rx_data), 32'(mon_e.data));
        end
      end
      if (rx_valid) begin
        valid_cnt++;
        prev_valid_cyc = last_valid_cyc;
        last_valid_cyc = cyc;
      end
      if (frame_err) err_cnt++;
      if (match) begin
        match_cnt++;
        check("match_after_space", 32'(prev_valid && prev_data == 8'h20), 32'd1);
      end
      prev_valid = rx_valid;
      prev_data  = rx_data;
    end
  end

  task automatic send_bit(input logic b);
    rx_pin = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(stop);
  endtask

  task automatic push(input logic [7:0] d, input logic err);
    exp_t e;
    e.data = d;
    e.err  = err;
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    rx_pin = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, e0, m0;
    logic [7:0] last_good;

    vt[0] = '{din: 8'h55, stop: 1'b1, exp_data: 8'h55, exp_err: 1'b0};
    vt[1] = '{din: 8'h00, stop: 1'b1, exp_data: 8'h00, exp_err: 1'b0};
    vt[2] = '{din: 8'hFF, stop: 1'b1, exp_data: 8'hFF, exp_err: 1'b0};
    vt[3] = '{din: 8'h80, stop: 1'b1, exp_data: 8'h80, exp_err: 1'b0};
    vt[4] = '{din: 8'h3C, stop: 1'b0, exp_data: 8'h80, exp_err: 1'b1};
    vt[5] = '{din: 8'h01, stop: 1'b1, exp_data: 8'h01, exp_err: 1'b0};
    vt[6] = '{din: 8'hC3, stop: 1'b1, exp_data: 8'hC3, exp_err: 1'b0};
    banner = '{8'h54, 8'h69, 8'h6E, 8'h79, 8'h20, 8'h54, 8'h61,
               8'h70, 8'h65, 8'h6F, 8'h75, 8'h74, 8'h20};

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({rx_data, rx_valid, frame_err, busy, match}), 32'd0);
    reset = 1'b1;
    idle(4);

    // Table of single frames
    last_good = 8'h00;
    for (int i = 0; i < 7; i++) begin
      v0 = valid_cnt;
      e0 = err_cnt;
      push(vt[i].exp_data, vt[i].exp_err);
      send_frame(vt[i].din, vt[i].stop);
      idle(CPB);
      drain("tbl_drain");
      if (!vt[i].exp_err) last_good = vt[i].exp_data;
      check("tbl_valid_cnt", 32'(valid_cnt - v0), vt[i].exp_err ? 32'd0 : 32'd1);
      check("tbl_err_cnt", 32'(err_cnt - e0), vt[i].exp_err ? 32'd1 : 32'd0);
      check("tbl_rx_data_held", 32'(rx_data), 32'(last_good));
      check("tbl_busy_idle", 32'(busy), 32'd0);
    end

    // Back-to-back frames, no idle gap
    push(8'hA3, 1'b0);
    push(8'h0F, 1'b0);
    send_frame(8'hA3, 1'b1);
    send_frame(8'h0F, 1'b1);
    idle(CPB);
    drain("b2b_drain");
    check("b2b_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd40);
    check("b2b_last_data", 32'(rx_data), 32'h0F);

    // One-cycle glitch
    v0 = valid_cnt;
    rx_pin = 1'b0;
    @(posedge clk);
    #1;
    rx_pin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("glitch_busy_high", 32'(busy), 32'd1);
    idle(6);
    check("glitch_busy_low", 32'(busy), 32'd0);
    check("glitch_no_valid", 32'(valid_cnt - v0), 32'd0);

    // Framing error followed by a held-low break
    v0 = valid_cnt;
    e0 = err_cnt;
    push(8'h41, 1'b1);
    send_frame(8'h41, 1'b0);
    rx_pin = 1'b0;
    repeat (5 * CPB) @(posedge clk);
    #1;
    check("ferr_count", 32'(err_cnt - e0), 32'd1);
    check("ferr_busy_in_break", 32'(busy), 32'd1);
    check("ferr_rx_data_kept", 32'(rx_data), 32'h0F);
    idle(CPB);
    check("ferr_busy_released", 32'(busy), 32'd0);
    check("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
    drain("ferr_drain");

    // Reset asserted during bit 3 of 0xFF
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    rx_pin = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({rx_data, rx_valid, frame_err, busy, match}), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_hold_outputs", 32'({rx_data, rx_valid, frame_err, busy, match}), 32'd0);
    reset = 1'b1;
    idle(2 * CPB);
    v0 = valid_cnt;
    push(8'h12, 1'b0);
    send_frame(8'h12, 1'b1);
    idle(CPB);
    drain("rst_drain");
    check("rst_one_valid", 32'(valid_cnt - v0), 32'd1);

    // Banner twice
    m0 = match_cnt;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 13; i++) begin
        push(banner[i], 1'b0);
        send_frame(banner[i], 1'b1);
      end
    idle(4 * CPB);
    drain("banner_drain");
    check("banner_x2_matches", 32'(match_cnt - m0), 32'(2 * MATCH_ON));

    // Leading extra 'T'
    m0 = match_cnt;
    push(8'h54, 1'b0);
    send_frame(8'h54, 1'b1);
    for (int i = 0; i < 13; i++) begin
      push(banner[i], 1'b0);
      send_frame(banner[i], 1'b1);
    end
    idle(4 * CPB);
    drain("tbanner_drain");
    check("tbanner_matches", 32'(match_cnt - m0), 32'(MATCH_ON));
    check("match_total", 32'(match_cnt), 32'(3 * MATCH_ON));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
